// File: rtl/dataram_block_mover.sv
// Block COPY / FILL engine that masters the 256x16 data RAM port while Busy is high.
// Every output is a flop; the RAM read data is sampled only on the RD->WR edge.
module dataram_block_mover #(
    parameter int ADDR_BITS = 8,
    parameter int LEN_BITS  = 9
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [ADDR_BITS-1:0] SrcAddr,
    input  logic [ADDR_BITS-1:0] DstAddr,
    input  logic [LEN_BITS-1:0]  Length,
    input  logic [15:0]          FillValue,
    output logic                 Busy,
    output logic                 Done,
    output logic [LEN_BITS-1:0]  WordsDone,
    output logic [15:0]          DataAddress,
    output logic                 MemWrite,
    output logic [15:0]          DataIn,
    input  logic [15:0]          DataOut
);

    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(2 ** ADDR_BITS);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} stateType;

    stateType             state;
    logic                 modeReg;
    logic [ADDR_BITS-1:0] srcReg;
    logic [ADDR_BITS-1:0] dstReg;
    logic [LEN_BITS-1:0]  lenReg;
    logic [LEN_BITS-1:0]  nextCount;

    assign nextCount = WordsDone + LEN_BITS'(1);

    // Word offset wraps inside the RAM; upper address bits are always zero.
    function automatic logic [15:0] busAddr(input logic [ADDR_BITS-1:0] base,
                                            input logic [ADDR_BITS-1:0] offset);
        logic [ADDR_BITS-1:0] sum;
        sum = base + offset;
        return {{(16 - ADDR_BITS){1'b0}}, sum};
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            modeReg     <= 1'b0;
            srcReg      <= '0;
            dstReg      <= '0;
            lenReg      <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            WordsDone   <= '0;
            DataAddress <= '0;
            MemWrite    <= 1'b0;
            DataIn      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        modeReg   <= Mode;
                        srcReg    <= SrcAddr;
                        dstReg    <= DstAddr;
                        lenReg    <= (Length > MAX_LEN) ? MAX_LEN : Length;
                        WordsDone <= '0;
                        Busy      <= 1'b1;
                        Done      <= 1'b0;
                        if (Length == '0) begin
                            state <= FIN;
                        end else if (!Mode) begin
                            state       <= RD;
                            DataAddress <= busAddr(SrcAddr, '0);
                        end else begin
                            state       <= WR;
                            DataAddress <= busAddr(DstAddr, '0);
                            MemWrite    <= 1'b1;
                            DataIn      <= FillValue;
                        end
                    end
                end
                RD: begin
                    // DataIn doubles as the copy hold register.
                    DataIn      <= DataOut;
                    DataAddress <= busAddr(dstReg, WordsDone[ADDR_BITS-1:0]);
                    MemWrite    <= 1'b1;
                    state       <= WR;
                end
                WR: begin
                    WordsDone <= nextCount;
                    if (nextCount == lenReg) begin
                        MemWrite <= 1'b0;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        state    <= FIN;
                    end else if (!modeReg) begin
                        MemWrite    <= 1'b0;
                        DataAddress <= busAddr(srcReg, nextCount[ADDR_BITS-1:0]);
                        state       <= RD;
                    end else begin
                        DataAddress <= busAddr(dstReg, nextCount[ADDR_BITS-1:0]);
                    end
                end
                FIN: begin
                    // A zero-length request arrives here with Done still low and
                    // spends one busy cycle before pulsing Done.
                    if (!Done) begin
                        Done <= 1'b1;
                        Busy <= 1'b0;
                    end else begin
                        Done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dataram_block_mover.sv
// Directed bench for dataram_block_mover with a behavioural 256x16 RAM
// (combinational read, write on the rising edge).
module tb_dataram_block_mover;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic        Mode;
    logic [7:0]  SrcAddr;
    logic [7:0]  DstAddr;
    logic [8:0]  Length;
    logic [15:0] FillValue;
    logic        Busy;
    logic        Done;
    logic [8:0]  WordsDone;
    logic [15:0] DataAddress;
    logic        MemWrite;
    logic [15:0] DataIn;
    logic [15:0] DataOut;

    logic [15:0] ram [256];
    logic        preWe = 1'b0;
    logic [7:0]  preAddr = '0;
    logic [15:0] preData = '0;
    int          writeCount = 0;
    int          hiErr = 0;
    int          checks = 0;
    int          failures = 0;
    int          k;
    int          w0;

    dataram_block_mover #(.ADDR_BITS(8), .LEN_BITS(9)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Mode(Mode),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
        .Busy(Busy), .Done(Done), .WordsDone(WordsDone),
        .DataAddress(DataAddress), .MemWrite(MemWrite), .DataIn(DataIn), .DataOut(DataOut)
    );

    always #5 CLK = ~CLK;

    assign DataOut = ram[DataAddress[7:0]];

    always @(posedge CLK) begin
        if (MemWrite) begin
            ram[DataAddress[7:0]] <= DataIn;
            writeCount <= writeCount + 1;
            if (DataAddress[15:8] !== 8'h00) hiErr <= hiErr + 1;
        end else if (preWe) begin
            ram[preAddr] <= preData;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        preAddr = a;
        preData = d;
        preWe   = 1'b1;
        tick();
        preWe   = 1'b0;
    endtask

    // Returns at E0+1 (k counts edges after E0).
    task automatic startOp(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [8:0] len, input logic [15:0] f);
        Mode = m; SrcAddr = s; DstAddr = d; Length = len; FillValue = f;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        $display("op mode=%0d src=%0h dst=%0h len=%0d fill=%0h", m, s, d, len, f);
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (Done !== 1'b1 && edges < 1000) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        RST = 1'b1; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
        Length = '0; FillValue = '0;
        tick(); tick();
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_words", WordsDone, 0);
        check("rst_addr", DataAddress, 0);
        check("rst_we", MemWrite, 0);
        check("rst_din", DataIn, 0);
        RST = 1'b0;
        tick();

        // COPY 0x10 -> 0x40, four words
        poke(8'h10, 16'h00A1); poke(8'h11, 16'h00B2); poke(8'h12, 16'h00C3); poke(8'h13, 16'h00D4);
        w0 = writeCount;
        startOp(1'b0, 8'h10, 8'h40, 9'd4, 16'h0);
        check("copy_busy", Busy, 1);
        waitDone(k);
        check("copy_done_edge", k, 8);
        check("copy_busy_at_done", Busy, 0);
        check("copy_words", WordsDone, 4);
        check("copy_nwrites", writeCount - w0, 4);
        check("copy_ram40", ram[8'h40], 16'h00A1);
        check("copy_ram41", ram[8'h41], 16'h00B2);
        check("copy_ram42", ram[8'h42], 16'h00C3);
        check("copy_ram43", ram[8'h43], 16'h00D4);
        tick();
        check("copy_done_pulse", Done, 0);
        check("copy_words_hold", WordsDone, 4);

        // FILL 0x80, three words; MemWrite high only between E0 and E3
        poke(8'h83, 16'h5555);
        startOp(1'b1, 8'h00, 8'h80, 9'd3, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_we_k%0d", i), MemWrite, (i < 3) ? 1 : 0);
            check($sformatf("fill_done_k%0d", i), Done, (i == 3) ? 1 : 0);
            tick();
        end
        check("fill_ram80", ram[8'h80], 16'hBEEF);
        check("fill_ram82", ram[8'h82], 16'hBEEF);
        check("fill_ram83", ram[8'h83], 16'h5555);

        // FILL wrapping past 0xFF
        w0 = hiErr;
        startOp(1'b1, 8'h00, 8'hFE, 9'd4, 16'h1234);
        waitDone(k);
        check("wrap_done_edge", k, 4);
        check("wrap_hibits", hiErr - w0, 0);
        check("wrap_ramFE", ram[8'hFE], 16'h1234);
        check("wrap_ramFF", ram[8'hFF], 16'h1234);
        check("wrap_ram00", ram[8'h00], 16'h1234);
        check("wrap_ram01", ram[8'h01], 16'h1234);
        tick();

        // zero-length COPY
        w0 = writeCount;
        startOp(1'b0, 8'h10, 8'h50, 9'd0, 16'h0);
        check("len0_busy_k0", Busy, 1);
        check("len0_done_k0", Done, 0);
        check("len0_we_k0", MemWrite, 0);
        tick();
        check("len0_done_k1", Done, 1);
        check("len0_busy_k1", Busy, 0);
        check("len0_words", WordsDone, 0);
        tick();
        check("len0_done_k2", Done, 0);
        check("len0_nwrites", writeCount - w0, 0);

        // FILL of 5 with a stray Start while busy
        poke(8'hA0, 16'h0000);
        w0 = writeCount;
        startOp(1'b1, 8'h00, 8'h90, 9'd5, 16'h7777);
        tick();
        Mode = 1'b0; DstAddr = 8'hA0; Length = 9'd2; Start = 1'b1;
        tick();
        Start = 1'b0;
        waitDone(k);
        check("ign_done_edge", k + 2, 5);
        check("ign_nwrites", writeCount - w0, 5);
        check("ign_words", WordsDone, 5);
        check("ign_ram94", ram[8'h94], 16'h7777);
        check("ign_ramA0", ram[8'hA0], 16'h0000);
        tick();

        // asynchronous reset during the third copy write
        poke(8'h60, 16'h0); poke(8'h61, 16'h0); poke(8'h62, 16'h0); poke(8'h63, 16'h0);
        startOp(1'b0, 8'h10, 8'h60, 9'd4, 16'h0);
        for (int i = 0; i < 5; i++) tick();
        check("arst_we_before", MemWrite, 1);
        #2 RST = 1'b1;
        #1;
        check("arst_we", MemWrite, 0);
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        tick();
        #2 RST = 1'b0;
        tick();
        check("arst_ram60", ram[8'h60], 16'h00A1);
        check("arst_ram61", ram[8'h61], 16'h00B2);
        check("arst_ram62", ram[8'h62], 16'h0000);
        check("arst_ram63", ram[8'h63], 16'h0000);
        startOp(1'b0, 8'h10, 8'h60, 9'd4, 16'h0);
        waitDone(k);
        check("arst_redo_edge", k, 8);
        check("arst_redo_ram63", ram[8'h63], 16'h00D4);
        tick();

        // overlapping forward copy propagates the first word
        poke(8'h20, 16'd1); poke(8'h21, 16'd2); poke(8'h22, 16'd3); poke(8'h23, 16'd4);
        startOp(1'b0, 8'h20, 8'h21, 9'd3, 16'h0);
        waitDone(k);
        check("ovl_done_edge", k, 6);
        check("ovl_ram21", ram[8'h21], 16'd1);
        check("ovl_ram22", ram[8'h22], 16'd1);
        check("ovl_ram23", ram[8'h23], 16'd1);
        tick();

        // oversize length clamps to the RAM size
        w0 = writeCount;
        startOp(1'b1, 8'h00, 8'h00, 9'd300, 16'hCAFE);
        waitDone(k);
        check("clamp_done_edge", k, 256);
        check("clamp_words", WordsDone, 256);
        check("clamp_nwrites", writeCount - w0, 256);
        check("clamp_ram83", ram[8'h83], 16'hCAFE);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dataram_block_mover.md
Name: dataram_block_mover

Overview:
- Bus initiator for the 256x16 data RAM: drives DataAddress, MemWrite and DataIn, and consumes the RAM's combinational DataOut.
- Performs block COPY (src to dst) and block FILL (constant to dst) of up to 256 words without CPU involvement.
- Sits beside the CPU datapath; a top-level mux grants it the RAM port while Busy=1.
- Frees the ISA from multi-instruction memset/memcpy loops.

Parameters:
- ADDR_BITS, 8, RAM index width; the upper 16-ADDR_BITS bits of DataAddress are always driven 0.
- LEN_BITS, 9, width of Length/WordsDone; must hold 2^ADDR_BITS.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  request pulse; sampled only when Busy=0.
- Mode  in  1  0=COPY, 1=FILL; latched at Start.
- SrcAddr  in  ADDR_BITS  copy source base; latched at Start.
- DstAddr  in  ADDR_BITS  destination base; latched at Start.
- Length  in  LEN_BITS  word count, 0..256; latched at Start.
- FillValue  in  16  fill data; latched at Start.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- WordsDone  out  LEN_BITS  words written so far in the current or last operation.
- DataAddress  out  16  RAM address.
- MemWrite  out  1  RAM write enable.
- DataIn  out  16  RAM write data.
- DataOut  in  16  RAM read data, combinational from DataAddress.

Behaviour:
- Reset value of every output: 0. This applies to Busy, Done, WordsDone, DataAddress, MemWrite and DataIn.
- Reset is asynchronous: asserting RST mid-operation drops MemWrite immediately.
  - Words already written stay written; no Done pulse is issued.
- All outputs are registered (driven directly from flops), so there are no combinational paths from inputs to outputs.
- States: IDLE, RD, WR, FIN.
- In IDLE with Start=1 at edge E0, the block latches its inputs, clears WordsDone and sets Busy=1. The next state depends on Mode and Length:
  - Length=0: go to FIN.
  - COPY: go to RD.
  - FILL: go to WR.
- RD (COPY only):
  - DataAddress = (Src + WordsDone) mod 2^ADDR_BITS, MemWrite=0.
  - At the next edge, DataOut is captured into a hold register; go to WR.
- WR:
  - DataAddress = (Dst + WordsDone) mod 2^ADDR_BITS, MemWrite=1.
  - DataIn = hold register in COPY, FillValue in FILL.
  - At the next edge the RAM commits the write and WordsDone increments.
  - If WordsDone+1 = Length, go to FIN; otherwise go to RD (COPY) or stay in WR (FILL).
- FIN: Done=1 and Busy=0 for exactly one cycle, MemWrite=0; go to IDLE.
- Latency:
  - COPY of N words: writes commit at edges E2, E4, ..., E2N; Done is high in the cycle after E(2N).
  - FILL of N words: writes commit at edges E1..EN; Done is high in the cycle after EN.
  - Length=0: Done is high in the cycle after E1, with no writes.
- Address arithmetic wraps modulo 2^ADDR_BITS: base 0xFE with length 4 touches 0xFE, 0xFF, 0x00, 0x01.
- Length greater than 2^ADDR_BITS is clamped to 2^ADDR_BITS at latch time.
- Overlapping COPY always proceeds low-to-high, one word at a time.
  - With dst = src+k (0 < k < Length), the first k source words repeat across the destination (forward-propagation semantics). This is defined behaviour.
- Start while Busy=1 is ignored; latched inputs do not change.
- Start in the FIN cycle is ignored: Busy=0, but the state is not IDLE yet. The earliest accepted Start is the cycle after Done.
- WordsDone holds its final value after Done until the next accepted Start.
- MemWrite is never high outside state WR.

Test Plan:
- Preload RAM[0x10..0x13]={A1,B2,C3,D4}; COPY Src=0x10, Dst=0x40, Len=4 -> RAM[0x40..0x43]={A1,B2,C3,D4}; Done in the cycle after E8; WordsDone=4.
- FILL Dst=0x80, Len=3, FillValue=0xBEEF -> RAM[0x80..0x82]=0xBEEF and RAM[0x83] unchanged; MemWrite high exactly for edges E1..E3.
- FILL Dst=0xFE, Len=4, value 0x1234 -> RAM[0xFE], RAM[0xFF], RAM[0x00], RAM[0x01]=0x1234; DataAddress[15:8]=0 throughout.
- Len=0 COPY -> Busy high for 1 cycle, Done pulse after E1, no MemWrite, WordsDone=0; a Start pulse during Busy of a Len=5 FILL is ignored, with exactly 5 writes.
- RST asserted mid-COPY after the 2nd write -> MemWrite, Busy and Done go 0 asynchronously; only 2 destination words are modified; a new Start after reset completes normally.
- Overlap COPY Src=0x20, Dst=0x21, Len=3 with RAM[0x20..0x23]={1,2,3,4} -> RAM[0x20..0x23]={1,1,1,1}.
